// File: rtl/line_pkg.sv
// Shared constants and FSM state encoding for the playfield row scheduler.
package line_pkg;

  localparam int unsigned LINE_WIDTH = 640;
  localparam int unsigned ROW_CNT_W  = 16;
  localparam int unsigned LEVEL_MAX  = 15;

  typedef logic [1:0] state_t;
  localparam state_t IDLE       = 2'd0;
  localparam state_t FILL_SOLID = 2'd1;
  localparam state_t FILL_RAND  = 2'd2;
  localparam state_t DONE       = 2'd3;

endpackage

// File: rtl/line_pacer.sv
// Row schedule: preamble, gap and spacing counters plus the difficulty level.
module line_pacer
  import line_pkg::*;
#(
  parameter int unsigned PreambleLines = 8,
  parameter int unsigned InitSpacing   = 6,
  parameter int unsigned MinSpacing    = 2,
  parameter int unsigned LevelRows     = 4
) (
  input  logic       clk_line,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       advance_i,
  input  logic       kind_i,
  output logic       next_is_rand_o,
  output logic [3:0] level_o
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] PRE_INIT = CW'(PreambleLines);
  localparam logic [CW-1:0] SPC_INIT = CW'(InitSpacing);
  localparam logic [CW-1:0] SPC_MIN  = CW'(MinSpacing);
  localparam logic [CW-1:0] LVL_ROWS = CW'(LevelRows);
  localparam logic [3:0]    LVL_MAX  = 4'(LEVEL_MAX);

  logic [CW-1:0] pre_q, pre_d, gap_q, gap_d, spc_q, spc_d, lvc_q, lvc_d;
  logic [3:0]    level_q, level_d;

  assign next_is_rand_o = (pre_q == '0) && (gap_q == '0);
  assign level_o        = level_q;

  always_comb begin
    pre_d   = pre_q;
    gap_d   = gap_q;
    spc_d   = spc_q;
    lvc_d   = lvc_q;
    level_d = level_q;
    if (clear_i) begin
      pre_d   = PRE_INIT;
      gap_d   = SPC_INIT;
      spc_d   = SPC_INIT;
      lvc_d   = '0;
      level_d = '0;
    end else if (advance_i) begin
      if (pre_q != '0) begin
        pre_d = pre_q - ONE;
      end else if (!kind_i) begin
        if (gap_q != '0) gap_d = gap_q - ONE;
      end else begin
        // gap reloads from the spacing in force before this row's level-up
        gap_d = spc_q;
        if (lvc_q + ONE == LVL_ROWS) begin
          lvc_d = '0;
          if (level_q != LVL_MAX) level_d = level_q + 4'd1;
          if (spc_q > SPC_MIN) spc_d = spc_q - ONE;
        end else begin
          lvc_d = lvc_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_line or negedge rst_i) begin
    if (!rst_i) begin
      pre_q   <= PRE_INIT;
      gap_q   <= SPC_INIT;
      spc_q   <= SPC_INIT;
      lvc_q   <= '0;
      level_q <= '0;
    end else begin
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      spc_q   <= spc_d;
      lvc_q   <= lvc_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/line_sched.sv
// Row sequencer: drives the generator type select, flags finished rows, tracks requests.
module line_sched
  import line_pkg::*;
#(
  parameter int unsigned LineWidth     = LINE_WIDTH,
  parameter int unsigned PreambleLines = 8,
  parameter int unsigned InitSpacing   = 6,
  parameter int unsigned MinSpacing    = 2,
  parameter int unsigned LevelRows     = 4
) (
  input  logic                 clk_line,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 restart_i,
  input  logic                 req_i,
  output logic                 line_type_o,
  output logic                 line_valid_o,
  output logic                 line_is_rand_o,
  output logic                 busy_o,
  output logic                 ovf_o,
  output logic [3:0]           level_o,
  output logic [ROW_CNT_W-1:0] rows_o
);

  localparam int unsigned FW = $clog2(LineWidth);
  localparam logic [FW-1:0]        FILL_INIT = FW'(LineWidth - 1);
  localparam logic [FW-1:0]        FONE      = FW'(1);
  localparam logic [ROW_CNT_W-1:0] ROW_ONE   = ROW_CNT_W'(1);

  state_t                state_q, state_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  pend_q, pend_d, kind_q, kind_d;
  logic                  ovf_d, type_d, valid_d, is_rand_d;
  logic [ROW_CNT_W-1:0]  rows_d;
  logic                  next_is_rand, accept, advance;

  assign accept  = (state_q == IDLE) && en_i && (req_i || pend_q);
  assign advance = (state_q == DONE) && !restart_i;
  assign busy_o  = (state_q != IDLE);

  line_pacer #(
    .PreambleLines (PreambleLines),
    .InitSpacing   (InitSpacing),
    .MinSpacing    (MinSpacing),
    .LevelRows     (LevelRows)
  ) u_pacer (
    .clk_line       (clk_line),
    .rst_i          (rst_i),
    .clear_i        (restart_i),
    .advance_i      (advance),
    .kind_i         (kind_q),
    .next_is_rand_o (next_is_rand),
    .level_o        (level_o)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    pend_d    = pend_q;
    kind_d    = kind_q;
    ovf_d     = ovf_o;
    rows_d    = rows_o;
    is_rand_d = line_is_rand_o;
    // outputs trail the state by one cycle so the generator's row is stable while valid is high
    type_d    = (state_q == FILL_RAND);
    valid_d   = (state_q == DONE);
    case (state_q)
      IDLE: if (accept) begin
        kind_d  = next_is_rand;
        state_d = next_is_rand ? FILL_RAND : FILL_SOLID;
        fill_d  = FILL_INIT;
      end
      FILL_SOLID: state_d = DONE;
      FILL_RAND: begin
        if (fill_q == '0) state_d = DONE;
        else              fill_d  = fill_q - FONE;
      end
      DONE: begin
        state_d   = IDLE;
        is_rand_d = kind_q;
        rows_d    = rows_o + ROW_ONE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      pend_d = 1'b0;
      if (req_i && pend_q) ovf_d = 1'b1;
    end else if (req_i) begin
      if (pend_q) ovf_d  = 1'b1;
      else        pend_d = 1'b1;
    end
    if (restart_i) begin
      state_d = IDLE;
      fill_d  = '0;
      pend_d  = 1'b0;
      kind_d  = 1'b0;
      ovf_d   = 1'b0;
      rows_d  = '0;
      type_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_line or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      fill_q         <= '0;
      pend_q         <= 1'b0;
      kind_q         <= 1'b0;
      ovf_o          <= 1'b0;
      rows_o         <= '0;
      line_type_o    <= 1'b0;
      line_valid_o   <= 1'b0;
      line_is_rand_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      pend_q         <= pend_d;
      kind_q         <= kind_d;
      ovf_o          <= ovf_d;
      rows_o         <= rows_d;
      line_type_o    <= type_d;
      line_valid_o   <= valid_d;
      line_is_rand_o <= is_rand_d;
    end
  end

endmodule
